load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage initiator for the byte-addressed, big-endian data memory. Turns CPU
//  lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-aligned memory transactions
//  (byte enables, lane steering, sign/zero extension) via a ready handshake.
//  Drives the pipeline stall while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYC  64  cycles in ACCESS without mem_ready before error response (0 = never)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   CPU request present
//  req_write     in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  req_unsigned  in   1   zero-extend loads (lbu/lhu)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  req_ready     out  1   request accepted this cycle (high only in IDLE)
//  rsp_valid     out  1   one-cycle pulse: transaction complete
//  rsp_rdata     out  32  extended load data (0 for stores and errors)
//  rsp_err       out  1   valid with rsp_valid: timeout or (macro) misalign
//  stall         out  1   high whenever state != IDLE
//  mem_addr      out  32  word address {addr[31:2],2'b00}
//  mem_wdata     out  32  lane-replicated store data
//  mem_be        out  4   byte enables; be[3] = bits[31:24] = byte offset 0
//  mem_read      out  1   held until mem_ready
//  mem_write     out  1   held until mem_ready
//  mem_ready     in   1   memory completes access this cycle
//  mem_rdata     in   32  read word, valid with mem_ready
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; all other outputs and regs 0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE:   req_ready=1; on req_valid capture request at edge, go ACCESS.
//   ACCESS: mem_read/mem_write, mem_addr, mem_be, mem_wdata held stable from
//           registered request; timeout counter increments each cycle.
//           mem_ready=1 -> capture mem_rdata, go RESP. Counter reaching
//           TIMEOUT_CYC-1 with no mem_ready -> drop strobe, rsp_err=1, go RESP.
//           mem_ready wins if both occur in the same cycle.
//   RESP:   rsp_valid=1 for exactly one cycle; go IDLE. New request not
//           accepted in RESP (min spacing 3 cycles).
//  Latency: accept at edge N; strobe visible N..; zero-wait memory -> rsp_valid in
//   cycle N+2.
//  Lanes (off = addr[1:0]): byte be=4'b1000>>off, wdata={4{b}}, read
//   mem_rdata[31-8*off -: 8]; half be=off[1]?0011:1100, wdata={2{h}};
//   word be=1111. Loads sign-extend unless req_unsigned; stores return 0.
//  Reset mid-ACCESS: strobes drop immediately; no response generated.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0
//   skips ACCESS (no strobe), IDLE -> RESP with rsp_err=1, rsp_rdata=0.
//  Not defined: offending low address bits forced to 0 (half clears bit0,
//   word clears bits1:0); access proceeds normally; rsp_err from timeout only.
// STRUCTURE
//  lsu_pkg: size encodings, FSM state enum, BE/lane constants, TIMEOUT width.
//  Sub-module lsu_lane_align: combinational BE generation, store replication,
//   load extraction and extension; FSM and counter remain in the top.
// TESTING
//  sw addr 0x10 data 0xDEADBEEF, mem_ready 0-wait -> be=1111, mem_addr 0x10, rsp_valid at N+2
//  lb addr 0x13, mem_rdata 0x112233F0 -> be=0001, rsp_rdata 0xFFFFFFF0; lbu -> 0x000000F0
//  lh addr 0x12, mem_rdata 0xAAAA8001 -> rsp_rdata 0xFFFF8001; sh 0x1234 -> wdata 0x12341234, be 0011
//  mem_ready withheld 64 cycles -> strobe drops, rsp_valid=1, rsp_err=1, stall clears next cycle
//  lw addr 0x22: macro on -> no strobe, rsp_err=1; macro off -> mem_addr 0x20, rsp_err=0
//  rst_n low during ACCESS -> strobes 0 asynchronously, IDLE, no rsp_valid after release

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   size_e     - request size encoding (11 is handled as a word)
//   state_e    - load_store_unit FSM states
//   BE_*       - byte-enable patterns; be[3] maps to bits [31:24] (byte offset 0)
//   TIMEOUT_W  - width of the ACCESS timeout counter (TIMEOUT_CYC must fit)
//   is_misaligned / align_addr - natural-alignment helpers
// Optional feature macro: MISALIGN_TRAP_EN (used by load_store_unit).
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam logic [3:0] BE_BYTE_MSB = 4'b1000;
    localparam logic [3:0] BE_HALF_HI  = 4'b1100;
    localparam logic [3:0] BE_HALF_LO  = 4'b0011;
    localparam logic [3:0] BE_WORD     = 4'b1111;

    localparam int unsigned TIMEOUT_W = 16;

    function automatic logic is_misaligned(input size_e s, input logic [1:0] off);
        case (s)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return |off;
        endcase
    endfunction

    // Clears the address bits that would make the access cross its natural boundary.
    function automatic logic [31:0] align_addr(input size_e s, input logic [31:0] a);
        case (s)
            SIZE_BYTE: return a;
            SIZE_HALF: return {a[31:1], 1'b0};
            default:   return {a[31:2], 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus interfaces of the load/store unit.
//   lsu_req_if : CPU-side request/response and stall.
//                master = CPU pipeline, slave = load_store_unit
//   lsu_mem_if : data-memory side with ready handshake.
//                master = load_store_unit, slave = memory
interface lsu_req_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

interface lsu_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_be, mem_read, mem_write,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_be, mem_read, mem_write,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for a big-endian 32-bit bus.
//   size, off      - access size and byte offset within the word
//   is_unsigned    - zero-extend loads instead of sign-extending
//   wdata          - right-justified store data
//   rdata          - word read from memory
//   be             - byte enables (be[3] = bits [31:24])
//   wdata_rep      - store data replicated across all lanes
//   rdata_ext      - extracted and extended load data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Offset 0 is the most significant lane.
        case (off)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SIZE_BYTE: begin
                be        = BE_BYTE_MSB >> off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                be        = off[1] ? BE_HALF_LO : BE_HALF_HI;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            default: begin
                be        = BE_WORD;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a byte-addressed big-endian data memory.
// Accepts one CPU request at a time (IDLE -> ACCESS -> RESP -> IDLE), drives a
// word-aligned memory transaction with byte enables, returns extended load data
// with a one-cycle rsp_valid pulse and holds stall while busy.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req         - lsu_req_if.slave  : CPU request/response/stall
//   mem         - lsu_mem_if.master : memory strobes, ready handshake, read data
// Parameter TIMEOUT_CYC: ACCESS cycles without mem_ready before an error
//   response (0 disables the timeout).
// Optional macro MISALIGN_TRAP_EN: misaligned half/word requests skip memory
//   and answer with rsp_err; without it the offending address bits are cleared.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    state_e                 state, state_nx;
    logic                   r_write;
    logic                   r_unsigned;
    size_e                  r_size;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [TIMEOUT_W-1:0]   cnt;
    logic [31:0]            rsp_data_q;
    logic                   rsp_err_q;

    logic                   accept;
    logic                   misalign;
    logic                   timeout;
    logic [3:0]             lane_be;
    logic [31:0]            lane_wdata;
    logic [31:0]            lane_rdata;

    assign accept = (state == ST_IDLE) && req.req_valid;

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_misaligned(size_e'(req.req_size), req.req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // mem_ready takes priority over an expiring counter in the same cycle.
    assign timeout = (TIMEOUT_CYC != 0) &&
                     (cnt == TIMEOUT_W'(TIMEOUT_CYC - 1)) &&
                     !mem.mem_ready;

    lsu_lane_align u_lane_align (
        .size        (r_size),
        .off         (r_addr[1:0]),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .rdata       (mem.mem_rdata),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = misalign ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ready || timeout) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Captured address is already aligned; with the trap enabled a misaligned
    // request never reaches ACCESS, so the alignment is harmless there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            r_write    <= req.req_write;
            r_unsigned <= req.req_unsigned;
            r_size     <= size_e'(req.req_size);
            r_addr     <= align_addr(size_e'(req.req_size), req.req_addr);
            r_wdata    <= req.req_wdata;
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= misalign;
        end else if (state == ST_ACCESS) begin
            cnt <= cnt + 1'b1;
            if (mem.mem_ready) begin
                rsp_data_q <= r_write ? '0 : lane_rdata;
                rsp_err_q  <= 1'b0;
            end else if (timeout) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        req.req_ready  = (state == ST_IDLE);
        req.stall      = (state != ST_IDLE);
        req.rsp_valid  = (state == ST_RESP);
        req.rsp_rdata  = '0;
        req.rsp_err    = 1'b0;
        mem.mem_read   = 1'b0;
        mem.mem_write  = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_be     = '0;
        mem.mem_wdata  = '0;
        if (state == ST_RESP) begin
            req.rsp_rdata = rsp_data_q;
            req.rsp_err   = rsp_err_q;
        end
        if (state == ST_ACCESS) begin
            mem.mem_read  = ~r_write;
            mem.mem_write = r_write;
            mem.mem_addr  = {r_addr[31:2], 2'b00};
            mem.mem_be    = lane_be;
            mem.mem_wdata = lane_wdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit.
// A byte-level reference model predicts bus address, byte enables, replicated
// store data and extended load data; a single compare process checks every
// output each cycle against the expected phase set by the driver.
// Honors MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

    logic clk;
    logic rst_n;

    lsu_req_if req_bus ();
    lsu_mem_if mem_bus ();

    load_store_unit #(.TIMEOUT_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int req_cyc  = 0;
    int strobe_cnt = 0;

    bit        mon_en     = 0;
    bit        exp_stall  = 0;
    bit        exp_strobe = 0;
    bit        exp_rsp    = 0;
    bit        exp_w      = 0;
    bit        exp_err    = 0;
    bit [31:0] exp_addr   = 0;
    bit [3:0]  exp_be     = 0;
    bit [31:0] exp_wdata  = 0;
    bit [31:0] exp_rdata  = 0;

    logic [31:0] last_addr, last_wdata, last_rsp_rdata;
    logic [3:0]  last_be;
    logic        last_rsp_err;
    int          last_rsp_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: works in bytes, not in lane patterns.
    function automatic void model(input bit w, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  input bit [31:0] rdata, output bit trap,
                                  output bit [31:0] waddr, output bit [3:0] be,
                                  output bit [31:0] wrep, output bit [31:0] ld);
        int n;
        int off;
        bit [31:0] a;
        bit [31:0] mask;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        trap = 0;
        if (addr % n != 0) begin
`ifdef MISALIGN_TRAP_EN
            trap = 1;
`endif
        end
        a     = addr - (addr % n);
        waddr = a & ~32'h3;
        off   = int'(a % 4);
        be    = 4'b0;
        for (int i = 0; i < n; i++) be[3 - (off + i)] = 1'b1;
        mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
        wrep  = 0;
        for (int j = 0; j < 4 / n; j++) wrep = (wrep << (8 * n)) | (wdata & mask);
        ld = 0;
        for (int i = 0; i < n; i++) ld = (ld << 8) | ((rdata >> (8 * (3 - (off + i)))) & 32'hFF);
        if (!uns && n < 4 && ld[8 * n - 1]) ld = ld | ~mask;
        if (w) ld = 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_bus.mem_read || mem_bus.mem_write) strobe_cnt++;
        if (mon_en) begin
            chk("stall", req_bus.stall, exp_stall);
            chk("req_ready", req_bus.req_ready, !exp_stall);
            chk("rsp_valid", req_bus.rsp_valid, exp_rsp);
            chk("mem_read", mem_bus.mem_read, exp_strobe && !exp_w);
            chk("mem_write", mem_bus.mem_write, exp_strobe && exp_w);
            if (exp_strobe) begin
                chk("mem_addr", mem_bus.mem_addr, exp_addr);
                chk("mem_be", mem_bus.mem_be, exp_be);
                if (exp_w) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
                last_addr  = mem_bus.mem_addr;
                last_be    = mem_bus.mem_be;
                last_wdata = mem_bus.mem_wdata;
            end
            if (exp_rsp) begin
                chk("rsp_rdata", req_bus.rsp_rdata, exp_rdata);
                chk("rsp_err", req_bus.rsp_err, exp_err);
                last_rsp_rdata = req_bus.rsp_rdata;
                last_rsp_err   = req_bus.rsp_err;
                last_rsp_cyc   = cyc;
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic txn(input bit w, input bit [1:0] sz, input bit uns, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit [31:0] rdata, input int wait_n);
        bit trap;
        bit timed_out;
        bit [31:0] ma;
        bit [3:0]  be;
        bit [31:0] wr;
        bit [31:0] ld;
        model(w, sz, uns, addr, wdata, rdata, trap, ma, be, wr, ld);
        exp_w = w; exp_addr = ma; exp_be = be; exp_wdata = wr;
        exp_stall = 0; exp_strobe = 0; exp_rsp = 0;
        strobe_cnt = 0;
        req_bus.req_valid    = 1'b1;
        req_bus.req_write    = w;
        req_bus.req_size     = sz;
        req_bus.req_unsigned = uns;
        req_bus.req_addr     = addr;
        req_bus.req_wdata    = wdata;
        req_cyc = cyc;
        @(posedge clk); #1;
        req_bus.req_valid = 1'b0;
        req_bus.req_wdata = $urandom;
        req_bus.req_addr  = $urandom;
        timed_out = 0;
        if (!trap) begin
            for (int k = 0; k < 64; k++) begin
                exp_stall = 1; exp_strobe = 1;
                mem_bus.mem_ready = (k == wait_n);
                mem_bus.mem_rdata = (k == wait_n) ? rdata : $urandom;
                @(posedge clk); #1;
                mem_bus.mem_ready = 1'b0;
                if (k == wait_n) break;
                if (k == 63) timed_out = 1;
            end
        end
        exp_strobe = 0; exp_rsp = 1; exp_stall = 1;
        exp_err   = trap | timed_out;
        exp_rdata = exp_err ? 32'h0 : ld;
        @(posedge clk); #1;
        exp_rsp = 0; exp_stall = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int wn;
        req_bus.req_valid    = 1'b0;
        req_bus.req_write    = 1'b0;
        req_bus.req_size     = 2'b00;
        req_bus.req_unsigned = 1'b0;
        req_bus.req_addr     = '0;
        req_bus.req_wdata    = '0;
        mem_bus.mem_ready    = 1'b0;
        mem_bus.mem_rdata    = '0;
        rst_n = 1'b0;
        #1;
        chk("reset_req_ready", req_bus.req_ready, 1);
        chk("reset_stall", req_bus.stall, 0);
        chk("reset_rsp_valid", req_bus.rsp_valid, 0);
        chk("reset_strobes", {mem_bus.mem_read, mem_bus.mem_write}, 0);
        chk("reset_be", mem_bus.mem_be, 0);
        chk("reset_rsp_rdata", req_bus.rsp_rdata, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        txn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        chk("sw_addr", last_addr, 32'h10);
        chk("sw_be", last_be, 4'b1111);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_latency", last_rsp_cyc - req_cyc, 2);
        chk("sw_rdata", last_rsp_rdata, 0);

        txn(0, 2'b00, 0, 32'h13, 32'h0, 32'h112233F0, 0);
        chk("lb_be", last_be, 4'b0001);
        chk("lb_rdata", last_rsp_rdata, 32'hFFFFFFF0);
        txn(0, 2'b00, 1, 32'h13, 32'h0, 32'h112233F0, 2);
        chk("lbu_rdata", last_rsp_rdata, 32'h000000F0);

        txn(0, 2'b01, 0, 32'h12, 32'h0, 32'hAAAA8001, 1);
        chk("lh_rdata", last_rsp_rdata, 32'hFFFF8001);
        txn(1, 2'b01, 0, 32'h12, 32'h1234, 32'h0, 0);
        chk("sh_wdata", last_wdata, 32'h12341234);
        chk("sh_be", last_be, 4'b0011);

        txn(0, 2'b10, 0, 32'h40, 32'h0, 32'h55AA55AA, 1000);
        chk("timeout_err", last_rsp_err, 1);
        chk("timeout_strobe_cycles", strobe_cnt, 64);
        txn(0, 2'b10, 0, 32'h44, 32'h0, 32'h0BADF00D, 63);
        chk("last_cycle_ready_err", last_rsp_err, 0);
        chk("last_cycle_ready_data", last_rsp_rdata, 32'h0BADF00D);

        txn(0, 2'b10, 0, 32'h22, 32'h0, 32'h01020304, 0);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_strobes", strobe_cnt, 0);
        chk("misalign_err", last_rsp_err, 1);
`else
        chk("misalign_addr", last_addr, 32'h20);
        chk("misalign_err", last_rsp_err, 0);
        chk("misalign_data", last_rsp_rdata, 32'h01020304);
`endif

        // Reset in the middle of ACCESS.
        mon_en = 0;
        req_bus.req_valid = 1'b1;
        req_bus.req_write = 1'b0;
        req_bus.req_size  = 2'b10;
        req_bus.req_addr  = 32'h100;
        @(posedge clk); #1;
        req_bus.req_valid = 1'b0;
        chk("rst_pre_read", mem_bus.mem_read, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_read_drop", mem_bus.mem_read, 0);
        chk("rst_stall_drop", req_bus.stall, 0);
        chk("rst_req_ready", req_bus.req_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_stall = 0; exp_strobe = 0; exp_rsp = 0;
        mon_en = 1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 19);
            if (r < 10)       wn = 0;
            else if (r < 18)  wn = $urandom_range(1, 3);
            else if (r == 18) wn = 63;
            else              wn = 64;
            txn($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                $urandom, $urandom, $urandom, wn);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
